// File: rtl/soundgen_note_sequencer_if.sv
// Register-side and audio-side signals of the note sequencer.
// The config master drives table writes and start/stop/loop; the sequencer drives audio/status.
interface soundgen_note_sequencer_if #(
  parameter int BW    = 8,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic          wr_en_i;
  logic [AW-1:0] wr_addr_i;
  logic [BW+3:0] wr_data_i;
  logic          start_i;
  logic          stop_i;
  logic          loop_i;
  logic          audio_o;
  logic          busy_o;
  logic [AW-1:0] note_idx_o;
  logic          done_o;

  modport master (
    output wr_en_i, wr_addr_i, wr_data_i, start_i, stop_i, loop_i,
    input  audio_o, busy_o, note_idx_o, done_o
  );

  modport slave (
    input  wr_en_i, wr_addr_i, wr_data_i, start_i, stop_i, loop_i,
    output audio_o, busy_o, note_idx_o, done_o
  );
endinterface

// File: rtl/soundgen_note_sequencer.sv
// Plays a melody from a writable note table as a square wave; each note costs one FETCH
// cycle plus dur*BEAT_LEN PLAY cycles. All outputs are registered; no backpressure.
module soundgen_note_sequencer #(
  parameter int BW       = 8,
  parameter int DEPTH    = 8,
  parameter int BEAT_LEN = 1000
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  soundgen_note_sequencer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = BW + 4;
  localparam int CW = $clog2(15 * BEAT_LEN + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_PLAY} state_t;

  state_t        r_state, w_state_nxt;
  logic [EW-1:0] r_table [DEPTH];
  logic [AW-1:0] r_idx, w_idx_nxt;
  logic [BW-1:0] r_pitch, w_pitch_nxt;
  logic [BW-1:0] r_tone_cnt, w_tone_cnt_nxt;
  logic [3:0]    r_dur, w_dur_nxt;
  logic [CW-1:0] r_note_cnt, w_note_cnt_nxt;
  logic          r_audio, w_audio_nxt;
  logic          r_done, w_done_nxt;
  logic [EW-1:0] w_entry;
  logic [CW-1:0] w_note_last;

  assign w_entry     = r_table[r_idx];
  assign w_note_last = CW'(r_dur) * CW'(BEAT_LEN) - CW'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) r_table[i] <= '0;
    end else if (bus.wr_en_i) begin
      r_table[bus.wr_addr_i] <= bus.wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_pitch    <= '0;
      r_dur      <= '0;
      r_tone_cnt <= '0;
      r_note_cnt <= '0;
      r_audio    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_pitch    <= w_pitch_nxt;
      r_dur      <= w_dur_nxt;
      r_tone_cnt <= w_tone_cnt_nxt;
      r_note_cnt <= w_note_cnt_nxt;
      r_audio    <= w_audio_nxt;
      r_done     <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_pitch_nxt    = r_pitch;
    w_dur_nxt      = r_dur;
    w_tone_cnt_nxt = r_tone_cnt;
    w_note_cnt_nxt = r_note_cnt;
    w_audio_nxt    = r_audio;
    w_done_nxt     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.start_i) begin
          w_state_nxt = ST_FETCH;
          w_idx_nxt   = '0;
        end
      end
      ST_FETCH: begin
        w_pitch_nxt    = w_entry[BW-1:0];
        w_dur_nxt      = w_entry[BW+3:BW];
        w_tone_cnt_nxt = '0;
        w_note_cnt_nxt = '0;
        w_audio_nxt    = 1'b0;
        if (w_entry[BW+3:BW] != 4'd0) begin
          w_state_nxt = ST_PLAY;
        end else if (bus.loop_i && r_idx != '0) begin
          // End marker past entry 0 rewinds; a marker at entry 0 always terminates.
          w_idx_nxt = '0;
        end else begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      ST_PLAY: begin
        if (r_pitch == '0) begin
          w_audio_nxt = 1'b0;
        end else if (r_tone_cnt == r_pitch - BW'(1)) begin
          w_tone_cnt_nxt = '0;
          w_audio_nxt    = ~r_audio;
        end else begin
          w_tone_cnt_nxt = r_tone_cnt + BW'(1);
        end

        if (r_note_cnt == w_note_last) begin
          w_idx_nxt      = r_idx + AW'(1);
          w_note_cnt_nxt = '0;
          w_audio_nxt    = 1'b0;
          if (r_idx == AW'(DEPTH - 1) && !bus.loop_i) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_FETCH;
          end
        end else begin
          w_note_cnt_nxt = r_note_cnt + CW'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (bus.stop_i) begin
      w_state_nxt = ST_IDLE;
      w_idx_nxt   = r_idx;
      w_audio_nxt = 1'b0;
      w_done_nxt  = 1'b0;
    end
  end

  assign bus.audio_o    = r_audio;
  assign bus.busy_o     = (r_state != ST_IDLE);
  assign bus.note_idx_o = r_idx;
  assign bus.done_o     = r_done;
endmodule

// File: tb/tb_soundgen_note_sequencer.sv
// Bench for soundgen_note_sequencer: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a note-timeline model.
module tb_soundgen_note_sequencer;
  localparam int BW = 8, DEPTH = 4, BL = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  soundgen_note_sequencer_if #(.BW(BW), .DEPTH(DEPTH)) bus ();
  soundgen_note_sequencer #(.BW(BW), .DEPTH(DEPTH), .BEAT_LEN(BL)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase 0 is the fetch slot, phases 1..dur*BL are the sounding cycles of a note.
  int m_busy = 0, m_idx = 0, m_phase = 0, m_pitch = 0, m_dur = 0, m_done = 0;
  logic [11:0] m_table [DEPTH];
  logic [11:0] m_e;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_idx = 0; m_phase = 0; m_pitch = 0; m_dur = 0; m_done = 0;
      for (int i = 0; i < DEPTH; i++) m_table[i] = '0;
    end else begin
      m_done = 0;
      m_e = m_table[m_idx];
      if (bus.stop_i) begin
        m_busy = 0;
      end else if (m_busy == 0) begin
        if (bus.start_i) begin m_busy = 1; m_idx = 0; m_phase = 0; end
      end else if (m_phase == 0) begin
        if (m_e[11:8] == 4'd0) begin
          if (bus.loop_i && m_idx != 0) m_idx = 0;
          else begin m_busy = 0; m_done = 1; end
        end else begin
          m_pitch = int'(m_e[7:0]); m_dur = int'(m_e[11:8]); m_phase = 1;
        end
      end else if (m_phase == m_dur * BL) begin
        if (m_idx == DEPTH - 1 && !bus.loop_i) begin m_busy = 0; m_done = 1; end
        else m_phase = 0;
        m_idx = (m_idx + 1) % DEPTH;
      end else begin
        m_phase++;
      end
      if (bus.wr_en_i) m_table[bus.wr_addr_i] = bus.wr_data_i;
    end
  end

  function automatic int exp_audio();
    if (m_busy == 0 || m_phase == 0 || m_pitch == 0) return 0;
    return ((m_phase - 1) / m_pitch) % 2;
  endfunction

  always @(negedge clk) begin
    chk("busy", bus.busy_o, m_busy);
    chk("done", bus.done_o, m_done);
    chk("note_idx", bus.note_idx_o, m_idx);
    chk("audio", bus.audio_o, exp_audio());
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wr(input int a, input int d, input int p);
    bus.wr_en_i = 1'b1; bus.wr_addr_i = 2'(a); bus.wr_data_i = {4'(d), 8'(p)};
    cyc();
    bus.wr_en_i = 1'b0;
  endtask

  task automatic go();
    bus.start_i = 1'b1;
    cyc();
    bus.start_i = 1'b0;
  endtask

  int bsum, dsum, asum;
  logic [3:0] pat4;
  logic [11:0] pat12;

  initial begin
    bus.wr_en_i = 0; bus.wr_addr_i = 0; bus.wr_data_i = 0;
    bus.start_i = 0; bus.stop_i = 0; bus.loop_i = 0;
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();

    // Async reset in the middle of entry 1.
    wr(0, 1, 1); wr(1, 2, 3);
    go();
    repeat (7) cyc();
    @(posedge clk); #1;
    chk("pre_reset_busy", bus.busy_o, 1);
    chk("pre_reset_idx", bus.note_idx_o, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", bus.busy_o, 0);
    chk("arst_audio", bus.audio_o, 0);
    chk("arst_done", bus.done_o, 0);
    chk("arst_idx", bus.note_idx_o, 0);
    @(negedge clk) rst_n = 1'b1;
    cyc();
    // Cleared table: entry 0 is an end marker, which terminates even with loop set.
    bus.loop_i = 1'b1;
    go();
    chk("zero_tbl_fetch_busy", bus.busy_o, 1);
    cyc();
    chk("zero_tbl_done", bus.done_o, 1);
    chk("zero_tbl_busy", bus.busy_o, 0);
    bus.loop_i = 1'b0;
    cyc();

    // Single note: dur 1, pitch 2.
    wr(0, 1, 2); wr(1, 0, 0);
    go();
    bsum = 0; dsum = 0; pat4 = '0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) cyc();
      bsum += int'(bus.busy_o);
      dsum += int'(bus.done_o);
      if (c >= 1 && c <= 4) pat4 = {pat4[2:0], bus.audio_o};
      if (c == 5) chk("single_fetch1_idx", bus.note_idx_o, 1);
      if (c == 6) chk("single_done_cycle", bus.done_o, 1);
    end
    chk("single_busy_cycles", bsum, 6);
    chk("single_done_count", dsum, 1);
    chk("single_audio_pat", pat4, 4'b0011);

    // Rest note: dur 2, pitch 0.
    wr(0, 2, 0);
    go();
    bsum = 0; dsum = 0; asum = 0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) cyc();
      bsum += int'(bus.busy_o);
      dsum += int'(bus.done_o);
      asum += int'(bus.audio_o);
    end
    chk("rest_busy_cycles", bsum, 10);
    chk("rest_done_count", dsum, 1);
    chk("rest_audio_high", asum, 0);

    // Loop wrap over all four entries, then drop loop during entry 3.
    wr(0, 1, 1); wr(1, 1, 2); wr(2, 1, 3); wr(3, 1, 4);
    bus.loop_i = 1'b1;
    go();
    dsum = 0;
    for (int c = 0; c < 45; c++) begin
      if (c > 0) cyc();
      if (c % 5 == 0 && c <= 35) chk("loop_fetch_idx", bus.note_idx_o, (c / 5) % 4);
      if (c < 40) dsum += int'(bus.done_o);
      if (c == 40) begin
        chk("loop_end_done", bus.done_o, 1);
        chk("loop_end_busy", bus.busy_o, 0);
        chk("loop_end_idx", bus.note_idx_o, 0);
      end
      if (c == 36) bus.loop_i = 1'b0;
    end
    chk("loop_no_early_done", dsum, 0);

    // Stop mid-play, start+stop together, start while busy.
    wr(0, 3, 5); wr(1, 0, 0);
    go();
    repeat (4) cyc();
    bus.stop_i = 1'b1;
    cyc();
    bus.stop_i = 1'b0;
    chk("stop_busy", bus.busy_o, 0);
    chk("stop_audio", bus.audio_o, 0);
    chk("stop_done", bus.done_o, 0);
    repeat (3) cyc();
    bus.start_i = 1'b1; bus.stop_i = 1'b1;
    cyc();
    bus.start_i = 1'b0; bus.stop_i = 1'b0;
    chk("start_stop_busy", bus.busy_o, 0);
    wr(0, 1, 1); wr(1, 1, 2); wr(2, 0, 0);
    go();
    repeat (7) cyc();
    bus.start_i = 1'b1;
    cyc();
    bus.start_i = 1'b0;
    chk("restart_ignored_idx", bus.note_idx_o, 1);
    chk("restart_ignored_busy", bus.busy_o, 1);
    repeat (8) cyc();

    // Live edit of entry 1 while it plays.
    wr(0, 1, 1); wr(1, 1, 2); wr(2, 1, 3); wr(3, 1, 4);
    bus.loop_i = 1'b1;
    go();
    pat12 = '0;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) cyc();
      if (c == 8) bus.wr_en_i = 1'b0;
      if (c == 10) chk("edit_old_len_idx", bus.note_idx_o, 2);
      if (c >= 26 && c <= 37) pat12 = {pat12[10:0], bus.audio_o};
      if (c == 37) chk("edit_new_len_idx", bus.note_idx_o, 1);
      if (c == 38) chk("edit_next_idx", bus.note_idx_o, 2);
      if (c == 7) begin
        bus.wr_en_i = 1'b1; bus.wr_addr_i = 2'd1; bus.wr_data_i = {4'd3, 8'd5};
      end
    end
    chk("edit_audio_pat", pat12, 12'b000001111100);
    bus.loop_i = 1'b0;
    bus.stop_i = 1'b1;
    cyc();
    bus.stop_i = 1'b0;

    // Randomized traffic, with one asynchronous reset midway.
    for (int i = 0; i < 3000; i++) begin
      bus.wr_en_i   = ($urandom_range(3) == 0);
      bus.wr_addr_i = 2'($urandom_range(DEPTH - 1));
      bus.wr_data_i = {4'($urandom_range(3)), 8'($urandom_range(5))};
      bus.start_i   = ($urandom_range(7) == 0);
      bus.stop_i    = ($urandom_range(63) == 0);
      if ($urandom_range(31) == 0) bus.loop_i = ~bus.loop_i;
      cyc();
      if (i == 1500) begin
        @(posedge clk); #2 rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
      end
    end
    bus.wr_en_i = 0; bus.start_i = 0; bus.stop_i = 0;
    repeat (2) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
